// File: rtl/regfile_2r1w_if.sv
// Operand/bus interface of the 2-read/1-write register file: write port, two
// registered read ports, bus read select, clear handshake and debug taps.
interface regfile_2r1w_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [ADDR_W-1:0] rd_a_addr;
    logic [DATA_W-1:0] rd_a_data;
    logic [ADDR_W-1:0] rd_b_addr;
    logic [DATA_W-1:0] rd_b_data;
    logic              bus_oe;
    logic [ADDR_W-1:0] bus_addr;
    logic              clr_req;
    logic              clr_busy;
    logic              clr_done;
    logic              wr_drop;
    logic [DATA_W-1:0] rega;
    logic [DATA_W-1:0] regb;

    modport master (
        output wr_en, wr_addr, wr_data, rd_a_addr, rd_b_addr, bus_oe, bus_addr, clr_req,
        input  rd_a_data, rd_b_data, clr_busy, clr_done, wr_drop, rega, regb
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_a_addr, rd_b_addr, bus_oe, bus_addr, clr_req,
        output rd_a_data, rd_b_data, clr_busy, clr_done, wr_drop, rega, regb
    );
endinterface

// File: rtl/regfile_2r1w.sv
// Parametrised 2-read/1-write register file with tri-state bus read port and a
// one-entry-per-cycle clear sequencer. Optional macro REGFILE_ZERO_REG_EN hardwires entry 0 to zero.
module regfile_2r1w #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    regfile_2r1w_if.slave     bus,
    output wire  [DATA_W-1:0] bus_data_o
);

    localparam int NREGS = 2 ** ADDR_W;

    // state | meaning
    // IDLE  | normal operation, writes accepted, waiting for clr_req
    // SWEEP | clearing mem[ptr] each cycle, writes dropped
    // DONE  | one-cycle completion pulse, writes accepted, clr_req ignored
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [DATA_W-1:0] mem_q [NREGS];
    logic [DATA_W-1:0] rd_a_q, rd_a_d;
    logic [DATA_W-1:0] rd_b_q, rd_b_d;
    logic              clr_busy, clr_done, wr_drop;
    logic              wr_acc, wr_eff;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.clr_req) begin
                    state_d = ST_SWEEP;
                    ptr_d   = '0;
                end
            end
            ST_SWEEP: begin
                ptr_d = ptr_q + ADDR_W'(1);
                if (&ptr_q) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        clr_busy = 1'b0;
        clr_done = 1'b0;
        wr_drop  = 1'b0;
        case (state_q)
            ST_SWEEP: begin
                clr_busy = 1'b1;
                wr_drop  = bus.wr_en;
            end
            ST_DONE: clr_done = 1'b1;
            default: ;
        endcase
    end

    // An accepted write to entry 0 is silently absorbed when entry 0 is hardwired.
    always_comb begin
        wr_acc = bus.wr_en && !clr_busy;
`ifdef REGFILE_ZERO_REG_EN
        wr_eff = wr_acc && (bus.wr_addr != '0);
`else
        wr_eff = wr_acc;
`endif
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < NREGS; i++) mem_q[i] <= '0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (clr_busy && (ptr_q == ADDR_W'(i))) begin
                    mem_q[i] <= '0;
                end else if (wr_eff && (bus.wr_addr == ADDR_W'(i))) begin
                    mem_q[i] <= bus.wr_data;
                end
            end
        end
    end

    // Priority: entry being swept reads 0, then write-first bypass, then array.
    always_comb begin
        rd_a_d = mem_q[bus.rd_a_addr];
        if (wr_eff && (bus.wr_addr == bus.rd_a_addr)) rd_a_d = bus.wr_data;
        if (clr_busy && (ptr_q == bus.rd_a_addr)) rd_a_d = '0;
`ifdef REGFILE_ZERO_REG_EN
        if (bus.rd_a_addr == '0) rd_a_d = '0;
`endif
    end

    always_comb begin
        rd_b_d = mem_q[bus.rd_b_addr];
        if (wr_eff && (bus.wr_addr == bus.rd_b_addr)) rd_b_d = bus.wr_data;
        if (clr_busy && (ptr_q == bus.rd_b_addr)) rd_b_d = '0;
`ifdef REGFILE_ZERO_REG_EN
        if (bus.rd_b_addr == '0) rd_b_d = '0;
`endif
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rd_a_q <= '0;
            rd_b_q <= '0;
        end else begin
            rd_a_q <= rd_a_d;
            rd_b_q <= rd_b_d;
        end
    end

    assign bus.rd_a_data = rd_a_q;
    assign bus.rd_b_data = rd_b_q;
    assign bus.clr_busy  = clr_busy;
    assign bus.clr_done  = clr_done;
    assign bus.wr_drop   = wr_drop;
`ifdef REGFILE_ZERO_REG_EN
    assign bus.rega      = '0;
`else
    assign bus.rega      = mem_q[0];
`endif
    assign bus.regb      = mem_q[1];

    assign bus_data_o = bus.bus_oe ? mem_q[bus.bus_addr] : {DATA_W{1'bz}};

endmodule

// File: tb/tb_regfile_2r1w.sv
// Self-checking bench for regfile_2r1w: behavioural model feeds a scoreboard of
// expected read/flag values popped and compared one cycle after each stimulus.
module tb_regfile_2r1w;

    localparam int DW = 8;
    localparam int AW = 3;
    localparam int NR = 8;
`ifdef REGFILE_ZERO_REG_EN
    localparam bit ZR = 1'b1;
`else
    localparam bit ZR = 1'b0;
`endif

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    wire  [DW-1:0] bus_data;

    regfile_2r1w_if #(.DATA_W(DW), .ADDR_W(AW)) rf_if ();

    regfile_2r1w #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .bus        (rf_if),
        .bus_data_o (bus_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic          drop;
        logic          busy;
        logic          done;
    } exp_t;

    exp_t          sb_q[$];
    int            n_cmp = 0;
    int            n_err = 0;
    logic [DW-1:0] m_mem [NR];
    logic [1:0]    m_state;
    logic [AW-1:0] m_ptr;
    logic [DW-1:0] obs_a, obs_b;
    logic          obs_drop, obs_busy, obs_done;

    task automatic m_reset();
        for (int i = 0; i < NR; i++) m_mem[i] = '0;
        m_state = 2'd0;
        m_ptr   = '0;
    endtask

    function automatic logic m_wr_eff();
        return rf_if.wr_en && (m_state != 2'd1) && !(ZR && (rf_if.wr_addr == '0));
    endfunction

    function automatic logic [DW-1:0] m_read(input logic [AW-1:0] ra);
        if (ZR && (ra == '0)) return '0;
        if ((m_state == 2'd1) && (m_ptr == ra)) return '0;
        if (m_wr_eff() && (rf_if.wr_addr == ra)) return rf_if.wr_data;
        return m_mem[ra];
    endfunction

    task automatic drive_idle();
        rf_if.wr_en     = 1'b0;
        rf_if.wr_addr   = '0;
        rf_if.wr_data   = '0;
        rf_if.rd_a_addr = '0;
        rf_if.rd_b_addr = '0;
        rf_if.bus_oe    = 1'b0;
        rf_if.bus_addr  = '0;
        rf_if.clr_req   = 1'b0;
    endtask

    // One clock: sample combinational flags, push model expectation, advance model and DUT.
    task automatic tick();
        exp_t e;
        logic eff;
        #1;
        obs_drop = rf_if.wr_drop;
        obs_busy = rf_if.clr_busy;
        obs_done = rf_if.clr_done;
        e.a    = m_read(rf_if.rd_a_addr);
        e.b    = m_read(rf_if.rd_b_addr);
        e.drop = rf_if.wr_en && (m_state == 2'd1);
        e.busy = (m_state == 2'd1);
        e.done = (m_state == 2'd2);
        sb_q.push_back(e);
        eff = m_wr_eff();
        case (m_state)
            2'd0: if (rf_if.clr_req) begin m_state = 2'd1; m_ptr = '0; end
            2'd1: begin
                m_mem[m_ptr] = '0;
                if (m_ptr == AW'(NR - 1)) m_state = 2'd2;
                m_ptr = m_ptr + AW'(1);
            end
            default: m_state = 2'd0;
        endcase
        if (eff) m_mem[rf_if.wr_addr] = rf_if.wr_data;
        @(posedge clk);
        #1;
        obs_a = rf_if.rd_a_data;
        obs_b = rf_if.rd_b_data;
    endtask

    task automatic test_reset();
        drive_idle();
        rf_if.bus_oe   = 1'b1;
        rf_if.bus_addr = AW'(5);
        rst_n = 1'b0;
        m_reset();
        #22;
        n_cmp++; if (rf_if.rd_a_data !== '0) begin n_err++; $display("FAIL reset_rd_a: got %h expected 00", rf_if.rd_a_data); end
        n_cmp++; if (rf_if.rd_b_data !== '0) begin n_err++; $display("FAIL reset_rd_b: got %h expected 00", rf_if.rd_b_data); end
        n_cmp++; if ({rf_if.clr_busy, rf_if.clr_done, rf_if.wr_drop} !== 3'b000) begin n_err++; $display("FAIL reset_flags: got %b expected 000", {rf_if.clr_busy, rf_if.clr_done, rf_if.wr_drop}); end
        n_cmp++; if ({rf_if.rega, rf_if.regb} !== '0) begin n_err++; $display("FAIL reset_taps: got %h expected 0000", {rf_if.rega, rf_if.regb}); end
        n_cmp++; if (bus_data !== '0) begin n_err++; $display("FAIL reset_bus: got %h expected 00", bus_data); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        sb_q.delete();
    endtask

    task automatic test_write_read();
        exp_t e;
        drive_idle();
        rf_if.wr_en = 1'b1; rf_if.wr_addr = AW'(3); rf_if.wr_data = 8'hA5;
        tick(); void'(sb_q.pop_front());
        rf_if.wr_en = 1'b0; rf_if.rd_a_addr = AW'(3);
        tick(); e = sb_q.pop_front();
        n_cmp++; if (obs_a !== e.a) begin n_err++; $display("FAIL wr_rd_a: got %h expected %h", obs_a, e.a); end
        n_cmp++; if (obs_a !== 8'hA5) begin n_err++; $display("FAIL wr_rd_a_const: got %h expected a5", obs_a); end
        rf_if.bus_oe = 1'b1; rf_if.bus_addr = AW'(3);
        #1;
        n_cmp++; if (bus_data !== m_mem[3]) begin n_err++; $display("FAIL bus_rd: got %h expected %h", bus_data, m_mem[3]); end
        rf_if.bus_oe = 1'b0;
        #1;
        n_cmp++; if (!((bus_data === {DW{1'bz}}) || (bus_data === '0))) begin n_err++; $display("FAIL bus_release: got %h expected zz", bus_data); end
    endtask

    task automatic test_bypass();
        exp_t e;
        drive_idle();
        rf_if.wr_en = 1'b1; rf_if.wr_addr = AW'(5); rf_if.wr_data = 8'h3C;
        rf_if.rd_a_addr = AW'(5); rf_if.rd_b_addr = AW'(5);
        rf_if.bus_oe = 1'b1; rf_if.bus_addr = AW'(5);
        #1;
        n_cmp++; if (bus_data !== m_mem[5]) begin n_err++; $display("FAIL bus_no_bypass: got %h expected %h", bus_data, m_mem[5]); end
        tick(); e = sb_q.pop_front();
        n_cmp++; if (obs_a !== e.a) begin n_err++; $display("FAIL bypass_a: got %h expected %h", obs_a, e.a); end
        n_cmp++; if (obs_b !== e.b) begin n_err++; $display("FAIL bypass_b: got %h expected %h", obs_b, e.b); end
        n_cmp++; if (obs_drop !== e.drop) begin n_err++; $display("FAIL bypass_drop: got %b expected %b", obs_drop, e.drop); end
        rf_if.wr_en = 1'b0;
        #1;
        n_cmp++; if (bus_data !== m_mem[5]) begin n_err++; $display("FAIL bus_after_edge: got %h expected %h", bus_data, m_mem[5]); end
        rf_if.bus_oe = 1'b0;
    endtask

    task automatic test_clear();
        exp_t e;
        int   busy_cnt = 0;
        int   done_at  = -1;
        drive_idle();
        for (int i = 0; i < NR; i++) begin
            rf_if.wr_en = 1'b1; rf_if.wr_addr = AW'(i); rf_if.wr_data = DW'((i + 1) * 8'h11);
            tick(); void'(sb_q.pop_front());
        end
        rf_if.wr_en = 1'b0;
        rf_if.clr_req = 1'b1; rf_if.rd_b_addr = AW'(7);
        tick(); e = sb_q.pop_front();
        n_cmp++; if (obs_busy !== e.busy) begin n_err++; $display("FAIL clr_req_cycle_busy: got %b expected %b", obs_busy, e.busy); end
        rf_if.clr_req = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            rf_if.rd_a_addr = AW'(c - 1);
            tick(); e = sb_q.pop_front();
            n_cmp++; if ({obs_busy, obs_done} !== {e.busy, e.done}) begin n_err++; $display("FAIL sweep_flags c%0d: got %b%b expected %b%b", c, obs_busy, obs_done, e.busy, e.done); end
            n_cmp++; if (obs_a !== e.a) begin n_err++; $display("FAIL sweep_rd_a c%0d: got %h expected %h", c, obs_a, e.a); end
            n_cmp++; if (obs_b !== e.b) begin n_err++; $display("FAIL sweep_rd_b c%0d: got %h expected %h", c, obs_b, e.b); end
            if (obs_busy) busy_cnt++;
            if (obs_done && (done_at < 0)) done_at = c;
        end
        n_cmp++; if (busy_cnt != NR) begin n_err++; $display("FAIL busy_len: got %0d expected %0d", busy_cnt, NR); end
        n_cmp++; if (done_at != NR + 1) begin n_err++; $display("FAIL done_cycle: got %0d expected %0d", done_at, NR + 1); end
        for (int i = 0; i < NR; i++) begin
            rf_if.rd_a_addr = AW'(i); rf_if.rd_b_addr = AW'(NR - 1 - i);
            tick(); e = sb_q.pop_front();
            n_cmp++; if ({obs_a, obs_b} !== {e.a, e.b}) begin n_err++; $display("FAIL cleared_rd %0d: got %h %h expected %h %h", i, obs_a, obs_b, e.a, e.b); end
        end
        n_cmp++; if ({rf_if.rega, rf_if.regb} !== {m_mem[0], m_mem[1]}) begin n_err++; $display("FAIL cleared_taps: got %h %h expected %h %h", rf_if.rega, rf_if.regb, m_mem[0], m_mem[1]); end
    endtask

    task automatic test_wr_drop();
        exp_t e;
        bit   seen_done = 1'b0;
        drive_idle();
        rf_if.wr_en = 1'b1; rf_if.wr_addr = AW'(2); rf_if.wr_data = 8'h5A;
        tick(); void'(sb_q.pop_front());
        rf_if.wr_en = 1'b0; rf_if.clr_req = 1'b1;
        tick(); void'(sb_q.pop_front());
        rf_if.wr_en = 1'b1; rf_if.wr_addr = AW'(2); rf_if.wr_data = 8'hFF; rf_if.rd_a_addr = AW'(2);
        tick(); e = sb_q.pop_front();
        n_cmp++; if (obs_drop !== e.drop) begin n_err++; $display("FAIL wr_drop: got %b expected %b", obs_drop, e.drop); end
        n_cmp++; if (obs_a !== e.a) begin n_err++; $display("FAIL drop_no_bypass: got %h expected %h", obs_a, e.a); end
        rf_if.wr_en = 1'b0;
        for (int c = 0; c < 16 && !seen_done; c++) begin
            rf_if.clr_req = 1'b1;
            tick(); e = sb_q.pop_front();
            n_cmp++; if ({obs_busy, obs_done, obs_drop} !== {e.busy, e.done, e.drop}) begin n_err++; $display("FAIL restart_ignored c%0d: got %b%b%b expected %b%b%b", c, obs_busy, obs_done, obs_drop, e.busy, e.done, e.drop); end
            if (obs_done) seen_done = 1'b1;
        end
        n_cmp++; if (!seen_done) begin n_err++; $display("FAIL drop_sweep_timeout: got no clr_done expected clr_done"); end
        rf_if.clr_req = 1'b0;
        tick(); e = sb_q.pop_front();
        n_cmp++; if ({obs_busy, obs_a} !== {e.busy, e.a}) begin n_err++; $display("FAIL after_done: got %b %h expected %b %h", obs_busy, obs_a, e.busy, e.a); end
        tick(); e = sb_q.pop_front();
        n_cmp++; if (obs_a !== e.a) begin n_err++; $display("FAIL dropped_addr2: got %h expected %h", obs_a, e.a); end
    endtask

    task automatic test_reset_mid_sweep();
        exp_t e;
        int   busy_cnt = 0;
        int   done_at  = -1;
        drive_idle();
        for (int i = 0; i < NR; i++) begin
            rf_if.wr_en = 1'b1; rf_if.wr_addr = AW'(i); rf_if.wr_data = DW'(8'h40 + i);
            tick(); void'(sb_q.pop_front());
        end
        rf_if.wr_en = 1'b0; rf_if.clr_req = 1'b1;
        rf_if.rd_a_addr = AW'(6); rf_if.rd_b_addr = AW'(7);
        tick(); void'(sb_q.pop_front());
        rf_if.clr_req = 1'b0;
        repeat (3) begin tick(); void'(sb_q.pop_front()); end
        rf_if.bus_oe = 1'b1; rf_if.bus_addr = AW'(6);
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if ({rf_if.clr_busy, rf_if.clr_done} !== 2'b00) begin n_err++; $display("FAIL rst_mid_flags: got %b%b expected 00", rf_if.clr_busy, rf_if.clr_done); end
        n_cmp++; if ({rf_if.rd_a_data, rf_if.rd_b_data} !== '0) begin n_err++; $display("FAIL rst_mid_rd: got %h %h expected 00 00", rf_if.rd_a_data, rf_if.rd_b_data); end
        n_cmp++; if ({rf_if.rega, rf_if.regb, bus_data} !== '0) begin n_err++; $display("FAIL rst_mid_array: got %h %h %h expected 00 00 00", rf_if.rega, rf_if.regb, bus_data); end
        m_reset();
        sb_q.delete();
        repeat (3) begin
            @(posedge clk); #1;
            n_cmp++; if (rf_if.clr_done !== 1'b0) begin n_err++; $display("FAIL rst_no_done: got %b expected 0", rf_if.clr_done); end
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        rf_if.bus_oe = 1'b0; rf_if.clr_req = 1'b1;
        tick(); void'(sb_q.pop_front());
        rf_if.clr_req = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            tick(); e = sb_q.pop_front();
            n_cmp++; if ({obs_busy, obs_done} !== {e.busy, e.done}) begin n_err++; $display("FAIL resweep_flags c%0d: got %b%b expected %b%b", c, obs_busy, obs_done, e.busy, e.done); end
            if (obs_busy) busy_cnt++;
            if (obs_done && (done_at < 0)) done_at = c;
        end
        n_cmp++; if (busy_cnt != NR) begin n_err++; $display("FAIL resweep_len: got %0d expected %0d", busy_cnt, NR); end
        n_cmp++; if (done_at != NR + 1) begin n_err++; $display("FAIL resweep_done: got %0d expected %0d", done_at, NR + 1); end
    endtask

    task automatic test_zero_reg();
        exp_t e;
        drive_idle();
        rf_if.wr_en = 1'b1; rf_if.wr_addr = '0; rf_if.wr_data = 8'h77;
        rf_if.rd_a_addr = '0; rf_if.rd_b_addr = AW'(1);
        tick(); e = sb_q.pop_front();
        n_cmp++; if (obs_drop !== e.drop) begin n_err++; $display("FAIL zero_drop: got %b expected %b", obs_drop, e.drop); end
        n_cmp++; if (obs_a !== e.a) begin n_err++; $display("FAIL zero_bypass: got %h expected %h", obs_a, e.a); end
        rf_if.wr_en = 1'b0;
        tick(); e = sb_q.pop_front();
        n_cmp++; if (obs_a !== e.a) begin n_err++; $display("FAIL zero_read: got %h expected %h", obs_a, e.a); end
        n_cmp++; if (rf_if.rega !== m_mem[0]) begin n_err++; $display("FAIL zero_rega: got %h expected %h", rf_if.rega, m_mem[0]); end
    endtask

    task automatic test_random();
        exp_t e;
        drive_idle();
        for (int n = 0; n < 300; n++) begin
            rf_if.wr_en     = 1'($urandom_range(0, 1));
            rf_if.wr_addr   = AW'($urandom_range(0, NR - 1));
            rf_if.wr_data   = DW'($urandom);
            rf_if.rd_a_addr = AW'($urandom_range(0, NR - 1));
            rf_if.rd_b_addr = AW'($urandom_range(0, NR - 1));
            rf_if.clr_req   = ($urandom_range(0, 15) == 0);
            rf_if.bus_oe    = 1'($urandom_range(0, 1));
            rf_if.bus_addr  = AW'($urandom_range(0, NR - 1));
            tick(); e = sb_q.pop_front();
            n_cmp++; if ({obs_a, obs_b} !== {e.a, e.b}) begin n_err++; $display("FAIL rand_rd %0d: got %h %h expected %h %h", n, obs_a, obs_b, e.a, e.b); end
            n_cmp++; if ({obs_drop, obs_busy, obs_done} !== {e.drop, e.busy, e.done}) begin n_err++; $display("FAIL rand_flags %0d: got %b%b%b expected %b%b%b", n, obs_drop, obs_busy, obs_done, e.drop, e.busy, e.done); end
            n_cmp++; if ({rf_if.rega, rf_if.regb} !== {m_mem[0], m_mem[1]}) begin n_err++; $display("FAIL rand_taps %0d: got %h %h expected %h %h", n, rf_if.rega, rf_if.regb, m_mem[0], m_mem[1]); end
            if (rf_if.bus_oe) begin
                n_cmp++; if (bus_data !== m_mem[rf_if.bus_addr]) begin n_err++; $display("FAIL rand_bus %0d: got %h expected %h", n, bus_data, m_mem[rf_if.bus_addr]); end
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_write_read();
        test_bypass();
        test_clear();
        test_wr_drop();
        test_reset_mid_sweep();
        test_zero_reg();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
